// File: rtl/det_sched.sv
// det_sched: sequencing/arbitration controller for the combinational 5x5
// determinant unit. Two requesters are arbitrated round-robin. The granted
// matrix is registered onto the unit's input. After SETTLE_CYCLES cycles the
// determinant is captured and returned on a valid/ready response channel,
// tagged with the requester ID.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req0_valid/ready/matriz    requester 0 job channel (200-bit row-major matrix)
//   req1_valid/ready/matriz    requester 1 job channel
//   matriz_out                 registered matrix driven to determinante.matriz
//   det_in                     determinant from determinante.det
//   resp_valid/ready           response handshake
//   resp_det, resp_id          captured determinant and issuing requester
//   busy                       controller is not idle
module det_sched #(
  parameter int unsigned SETTLE_CYCLES = 3  // legal range 1..15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [199:0] req0_matriz,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [199:0] req1_matriz,
  output logic [199:0] matriz_out,
  input  logic [31:0]  det_in,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [31:0]  resp_det,
  output logic         resp_id,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       last_grant;
  logic       any_valid;
  logic       grant;

  // Round-robin: on a tie the requester that was not served last wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      matriz_out <= '0;
      resp_det   <= '0;
      resp_id    <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            matriz_out <= grant ? req1_matriz : req0_matriz;
            resp_id    <= grant;
            last_grant <= grant;
            cnt        <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt + 4'd1;
          // The unit is a multicycle path: sample only after the settle window.
          if (cnt == LAST_CNT) begin
            resp_det   <= det_in;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_det_sched.sv
// tb_det_sched: randomized and directed bench for det_sched with a
// transaction-level reference model checked every cycle.
module tb_det_sched;
  localparam int unsigned S = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [199:0] req0_matriz = '0, req1_matriz = '0;
  logic [199:0] matriz_out;
  logic [31:0]  det_in = '0;
  logic         resp_valid, resp_ready = 1'b0;
  logic [31:0]  resp_det;
  logic         resp_id, busy;

  always #5 clk = ~clk;

  det_sched #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_matriz(req0_matriz),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_matriz(req1_matriz),
    .matriz_out(matriz_out), .det_in(det_in),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_det(resp_det), .resp_id(resp_id), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 0;
  bit det_mode = 1;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [199:0] set_el(input logic [199:0] m, input int r, input int c,
                                          input logic [7:0] v);
    logic [199:0] t;
    t = m;
    t[199 - 8*(5*r + c) -: 8] = v;
    return t;
  endfunction

  function automatic logic [199:0] rand_mat();
    logic [223:0] t;
    t = '0;
    for (int i = 0; i < 7; i++) t = {t[191:0], 32'($urandom)};
    return t[199:0];
  endfunction

  // Fraction-free (Bareiss) elimination: exact integer determinant.
  function automatic longint det5(input logic [199:0] m);
    longint a[5][5];
    longint prev, tmp;
    longint sgn;
    int r;
    prev = 1;
    sgn  = 1;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        a[i][j] = longint'($signed(m[199 - 8*(5*i + j) -: 8]));
    for (int k = 0; k < 4; k++) begin
      if (a[k][k] == 0) begin
        r = -1;
        for (int i = k + 1; i < 5; i++) if (r < 0 && a[i][k] != 0) r = i;
        if (r < 0) return 0;
        for (int j = 0; j < 5; j++) begin
          tmp = a[k][j]; a[k][j] = a[r][j]; a[r][j] = tmp;
        end
        sgn = -sgn;
      end
      for (int i = k + 1; i < 5; i++)
        for (int j = k + 1; j < 5; j++)
          a[i][j] = (a[i][j] * a[k][k] - a[i][k] * a[k][j]) / prev;
      prev = a[k][k];
    end
    return sgn * a[4][4];
  endfunction

  // ---------------- reference model (job-level) ----------------
  bit           m_inflight = 0;
  bit           m_has_resp = 0;
  int           m_left     = 0;
  logic [199:0] m_matriz   = '0;
  logic [31:0]  m_det      = '0;
  logic         m_id       = 1'b0;
  logic         m_last     = 1'b1;

  function automatic bit m_idle();
    return !m_inflight && !m_has_resp;
  endfunction
  function automatic bit e_r0();
    return m_idle() && req0_valid && (!req1_valid || m_last);
  endfunction
  function automatic bit e_r1();
    return m_idle() && req1_valid && (!req0_valid || !m_last);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_inflight = 0; m_has_resp = 0; m_left = 0;
      m_matriz = '0; m_det = '0; m_id = 1'b0; m_last = 1'b1;
    end else if (m_idle()) begin
      if (e_r0() || e_r1()) begin
        m_id       = e_r1();
        m_matriz   = e_r1() ? req1_matriz : req0_matriz;
        m_last     = m_id;
        m_inflight = 1;
        m_left     = S;
      end
    end else if (m_inflight) begin
      m_left--;
      if (m_left == 0) begin
        m_inflight = 0;
        m_has_resp = 1;
        m_det      = det_in;
      end
    end else if (resp_ready) begin
      m_has_resp = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_req0_ready", req0_ready, e_r0());
      chk("m_req1_ready", req1_ready, e_r1());
      chk("m_busy", busy, !m_idle());
      chk("m_resp_valid", resp_valid, m_has_resp);
      chk("m_resp_det", resp_det, m_det);
      chk("m_resp_id", resp_id, m_id);
      chk("m_matriz_out", matriz_out, m_matriz);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    det_in = det_mode ? 32'(det5(matriz_out)) : 32'($urandom);
  endtask

  // Entered at posedge+1; returns at posedge+2 with resp_valid sampled.
  task automatic wait_resp(input string nm, input bit watch_r1);
    int n;
    n = 0;
    #1;
    while (!resp_valid && n < 4*S + 10) begin
      if (watch_r1) chk({nm, "_r1_blocked"}, req1_ready, 1'b0);
      tick();
      #1;
      n++;
    end
    chk({nm, "_resp_arrived"}, resp_valid, 1'b1);
  endtask

  logic [199:0] id_m, nr_m, tri_m;
  int           q_id[$];
  int           q_cyc[$];
  bit           acc0, acc1;
  logic [7:0]   diag [5];

  initial begin
    diag[0] = 8'd2; diag[1] = 8'd7; diag[2] = 8'd11; diag[3] = 8'd14; diag[4] = 8'd16;
    id_m = '0;
    for (int i = 0; i < 5; i++) id_m = set_el(id_m, i, i, 8'd1);
    tri_m = '0;
    for (int r = 0; r < 5; r++)
      for (int c = r; c < 5; c++)
        tri_m = set_el(tri_m, r, c, (c == r) ? diag[r] : 8'(r * 5 + c));
    nr_m = rand_mat();
    for (int c = 0; c < 5; c++) nr_m = set_el(nr_m, 2, c, 8'd0);

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk_en = 1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_matriz_out", matriz_out, 200'd0);
    chk("rst_resp_det", resp_det, 32'd0);
    chk("rst_resp_id", resp_id, 1'b0);

    // Identity job
    req0_matriz = id_m;
    req0_valid  = 1'b1;
    #1;
    chk("id_req0_ready", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("id_matriz_out", matriz_out, id_m);
    chk("id_busy", busy, 1'b1);
    for (int unsigned i = 1; i <= S; i++) begin
      tick();
      #1;
      chk("id_resp_valid_timing", resp_valid, i == S);
      chk("id_busy_hold", busy, 1'b1);
    end
    chk("id_resp_det", resp_det, 32'd1);
    chk("id_resp_id", resp_id, 1'b0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    chk("id_done_valid", resp_valid, 1'b0);
    chk("id_done_busy", busy, 1'b0);

    // Simultaneous requests after reset, then backpressure
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_matriz = nr_m;  req0_valid = 1'b1;
    req1_matriz = tri_m; req1_valid = 1'b1;
    #1;
    chk("sim_ready0", req0_ready, 1'b1);
    chk("sim_ready1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    wait_resp("sim_job0", 1'b1);
    chk("sim_det0", resp_det, 32'd0);
    chk("sim_id0", resp_id, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      chk("bp_valid", resp_valid, 1'b1);
      chk("bp_det", resp_det, 32'd0);
      chk("bp_id", resp_id, 1'b0);
      chk("bp_ready1", req1_ready, 1'b0);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_hs_ready1", req1_ready, 1'b0);
    tick();
    resp_ready = 1'b0;
    #1;
    chk("bp_grant1", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    wait_resp("sim_job1", 1'b0);
    chk("sim_det1", resp_det, 32'd34496);
    chk("sim_id1", resp_id, 1'b1);
    resp_ready = 1'b1;
    tick();

    // Fairness: both valid, resp_ready tied high
    det_mode = 0;
    req0_valid = 1'b1; req0_matriz = rand_mat();
    req1_valid = 1'b1; req1_matriz = rand_mat();
    for (int n = 0; n < 6 * (S + 2) + 10 && q_id.size() < 6; n++) begin
      #1;
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (acc0) begin q_id.push_back(0); q_cyc.push_back(cyc); end
      if (acc1) begin q_id.push_back(1); q_cyc.push_back(cyc); end
      tick();
      if (acc0) req0_matriz = rand_mat();
      if (acc1) req1_matriz = rand_mat();
    end
    chk("fair_job_count", 32'(q_id.size()), 32'd6);
    for (int i = 0; i < q_id.size(); i++) begin
      chk("fair_order", 32'(q_id[i]), 32'(i % 2));
      if (i > 0) chk("fair_spacing", 32'(q_cyc[i] - q_cyc[i-1]), 32'(S + 2));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int unsigned i = 0; i < S + 3; i++) tick();
    resp_ready = 1'b0;
    det_mode = 1;

    // Reset one cycle after acceptance
    req0_valid = 1'b1; req0_matriz = tri_m;
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstm_valid", resp_valid, 1'b0);
    chk("rstm_busy", busy, 1'b0);
    chk("rstm_matriz", matriz_out, 200'd0);
    chk("rstm_ready0_idle", req0_ready, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rstm_tie_ready0", req0_ready, 1'b1);
    chk("rstm_tie_ready1", req1_ready, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp_ready = 1'b1;
    for (int unsigned i = 0; i < S + 3; i++) begin
      tick();
      #1;
      chk("rstm_no_resp", resp_valid, 1'b0);
    end
    resp_ready = 1'b0;

    // Withdrawn request during SETTLE
    req0_valid = 1'b1; req0_matriz = id_m;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_matriz = tri_m;
    tick();
    req1_valid = 1'b0;
    wait_resp("wd", 1'b0);
    chk("wd_resp_id", resp_id, 1'b0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    chk("wd_no_second_resp", resp_valid, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("wd_tie_ready1", req1_ready, 1'b1);
    chk("wd_tie_ready0", req0_ready, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Randomized traffic
    det_mode = 0;
    for (int n = 0; n < 3000; n++) begin
      #1;
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      tick();
      rst = ($urandom_range(199) == 0);
      resp_ready = $urandom_range(1);
      if (acc0 || !req0_valid) begin
        req0_valid  = ($urandom_range(2) == 0);
        req0_matriz = rand_mat();
      end else if ($urandom_range(9) == 0) begin
        req0_valid = 1'b0;
      end
      if (acc1 || !req1_valid) begin
        req1_valid  = ($urandom_range(2) == 0);
        req1_matriz = rand_mat();
      end else if ($urandom_range(9) == 0) begin
        req1_valid = 1'b0;
      end
    end
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/det_sched.md
Name: det_sched

Overview:
Sequencing and arbitration controller for the combinational 5x5 determinant unit (`determinante`). It accepts matrix jobs from two requesters over valid/ready handshakes and arbitrates between them round-robin. It registers the granted matrix onto the unit's input and waits a programmable number of settle cycles, treating the unit as a multicycle path. It then captures the 32-bit determinant and returns it, tagged with the requester ID, on a valid/ready response channel.

Parameters:
SETTLE_CYCLES, 3, cycles between matrix registration and determinant capture; legal range 1..15.

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  synchronous reset, active-high
req0_valid  input  1  requester 0 has a job
req0_ready  output  1  requester 0 job accepted this cycle when valid&ready
req0_matriz  input  200  requester 0 matrix, row-major, a00 at [199:192], a44 at [7:0], signed 8-bit elements
req1_valid  input  1  requester 1 has a job
req1_ready  output  1  requester 1 handshake
req1_matriz  input  200  requester 1 matrix, same encoding
matriz_out  output  200  registered matrix driven to determinante.matriz
det_in  input  32  signed determinant from determinante.det
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_det  output  32  signed captured determinant
resp_id  output  1  requester that issued the job
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, rst=1 at a rising edge) sets the following:
  - state=IDLE, matriz_out=0, resp_det=0, resp_id=0, resp_valid=0, settle counter=0.
  - last_grant=1, so requester 0 wins the first tie.
- Reset mid-operation drops the in-flight job with no response. A held response is also discarded.
- States: IDLE, SETTLE, RESP.
- IDLE, grant selection:
  - Only one valid: grant that requester.
  - Both valid: grant the requester != last_grant.
- IDLE, ready outputs:
  - reqN_ready = (state==IDLE) && grant==N, combinational from the valids.
  - At most one ready is high in any cycle. Both readys are 0 outside IDLE.
- Acceptance edge (valid&ready):
  - matriz_out <= granted matrix; resp_id <= N; last_grant <= N.
  - counter <= 0; state -> SETTLE.
- SETTLE:
  - counter increments each edge.
  - On the edge where counter == SETTLE_CYCLES-1: resp_det <= det_in, resp_valid <= 1, state -> RESP.
  - resp_valid therefore rises exactly SETTLE_CYCLES cycles after the acceptance edge.
- RESP:
  - resp_valid, resp_det and resp_id are held stable until resp_ready=1.
  - On the handshake edge: resp_valid <= 0, state -> IDLE.
  - No new job is accepted on that same edge. Minimum job spacing is SETTLE_CYCLES+2 cycles.
- Requester rules:
  - Requesters hold valid and matriz stable until ready.
  - A request arriving while busy waits; there is no queueing inside the block.
  - Deasserting valid before ready withdraws the request. This is legal, and arbitration uses only the current valids.
- matriz_out keeps the last job's matrix after completion. It is not cleared in IDLE.
- Arithmetic: det_in passes through unmodified as signed 32-bit. No saturation or sign handling occurs in this block.
- busy = (state != IDLE), registered-state decode.

Test Plan:
- Identity job: req0 presents the identity matrix at edge T, SETTLE_CYCLES=3. Required: req0_ready=1 in cycle T; matriz_out=identity after T; resp_valid rises 3 cycles later with resp_det=1, resp_id=0; busy high throughout.
- Simultaneous requests after reset: req0 has the null-row matrix, req1 has the upper-triangular matrix with diagonal 2,7,11,14,16. Required order:
  - req0 served first: resp_det=0, resp_id=0.
  - req1 served next: resp_det=34496, resp_id=1.
  - req1_ready stays 0 until the first response handshake completes.
- Fairness: both valids held high continuously for 6 jobs, resp_ready tied 1. Required: resp_id sequence 0,1,0,1,0,1, with one job every SETTLE_CYCLES+2 cycles.
- Backpressure: resp_ready held 0 for 5 cycles after resp_valid, with req1_valid=1. Required: resp_det/resp_id stable, resp_valid stays 1, req1_ready=0 throughout; req1 is granted in the cycle after resp_ready=1.
- Reset mid-SETTLE: assert rst for 1 cycle, 1 cycle after acceptance. Required: next cycle resp_valid=0, busy=0, matriz_out=0, both readys follow IDLE rules; no response is ever produced for the aborted job.
- Withdrawn request: req1_valid pulses high during SETTLE and then drops before IDLE. Required: no grant or response for requester 1; last_grant unchanged.
